quad_paddle_decoder: RTL
========================

// Module: quad_paddle_decoder
// PURPOSE
//  Front end for the rotary-encoder paddle input of the VGA pong game.
//  Synchronises the raw quadA/quadB pins and rejects glitches with a per-channel
//  stability filter. Decodes the Gray-code transitions into a saturating paddle
//  position, plus one-cycle step and illegal-transition pulses.
//  Sits between the board pins and the game logic; the game consumes the cleaned
//  quadrature outputs or the position directly.
// PARAMETERS
//  FILT_LEN  4    cycles a synchronised level must be stable before it is accepted (>=1)
//  POS_W     9    width of position
//  POS_MAX   511  upper clamp of position (<= 2**POS_W-1)
//  POS_INIT  0    position value loaded at reset
// PORTS
//  clk          in   1      system/pixel clock; single clock domain
//  reset_n      in   1      asynchronous, active-low reset
//  quadA        in   1      raw encoder channel A (asynchronous to clk)
//  quadB        in   1      raw encoder channel B (asynchronous to clk)
//  quadA_clean  out  1      filtered channel A
//  quadB_clean  out  1      filtered channel B
//  position     out  POS_W  saturating paddle position
//  step_up      out  1      1-cycle pulse, position incremented (or clamped at POS_MAX)
//  step_dn      out  1      1-cycle pulse, position decremented (or clamped at 0)
//  illegal      out  1      1-cycle pulse, both clean channels changed in the same cycle
// BEHAVIOUR
//  Reset (async assert, sync-style release on clk): all sync flops and clean outputs 0,
//   filter counters 0, position=POS_INIT, step_up/step_dn/illegal 0, FSM=PRIME.
//  Sync: 2-flop synchroniser per channel -> s_A, s_B.
//  Filter (per channel, counter c, width clog2(FILT_LEN)+1):
//   - s==clean: c<=0.
//   - s!=clean and c==FILT_LEN-1: clean<=s, c<=0.
//   - otherwise: c<=c+1.
//   - Any level held < FILT_LEN cycles at s is dropped. FILT_LEN=1 means accept next cycle.
//  FSM:
//   - PRIME: clean<=s every cycle, no decode, outputs pulses 0; prime counter runs
//     FILT_LEN+2 cycles, then -> RUN.
//   - RUN: filter as above; decode every cycle.
//  Decode (RUN), prev={A,B} clean from the previous cycle, new = current clean:
//   - no change: nothing.
//   - exactly one bit changed: up if prev_A ^ new_B, else down.
//     Up sequence is 00->01->11->10->00.
//   - both changed: illegal<=1; position and step pulses unchanged.
//  Position:
//   - up: position<=min(position+1, POS_MAX).
//   - down: position<=max(position-1, 0).
//   - step_up/step_dn pulse even when clamped.
//   - No wrap-around, ever.
//  Latency: raw edge stable before edge x -> clean changes after edge x+1+FILT_LEN ->
//   position/pulse registered after edge x+2+FILT_LEN (FILT_LEN+3 edges).
//  Pulses are registered, high exactly one cycle, mutually exclusive.
//  Reset mid-operation: everything returns to reset values immediately; the FSM
//   re-enters PRIME so the pin level at release never produces a false step or illegal.
// CONFIGURATION
//  QUAD_ERRCNT_EN defined:
//   - adds output err_count [7:0]: reset 0, +1 per illegal pulse, saturates at 255.
//   - adds input err_clr [0:0]: synchronous clear; if it coincides with illegal, the
//     result is 0.
//  QUAD_ERRCNT_EN undefined:
//   - neither port exists; the illegal pulse behaves identically.
// TESTING
//  1 Reset with A=B=1 held, release -> after PRIME clean=11, position=POS_INIT,
//    no step/illegal ever.
//  2 Four clean up-steps (00->01->11->10->00, 20 cycles each), FILT_LEN=4 ->
//    position 0->4, four step_up pulses, each 7 edges after its pin edge.
//  3 3-cycle glitch on A -> quadA_clean unchanged, no pulses;
//    4-cycle pulse -> accepted.
//  4 Position at POS_MAX=511 plus one up-step -> stays 511, step_up pulses;
//    at 0 plus one down-step -> stays 0, step_dn pulses.
//  5 A and B toggle on the same cycle (00->11) -> illegal one cycle, position unchanged;
//    with QUAD_ERRCNT_EN, err_count=1; 300 more -> 255; err_clr -> 0.
//  6 Assert reset_n=0 mid-step (filter counter at 2) -> outputs reset asynchronously;
//    no pulse after release.

Source files
------------

// File: rtl/quad_paddle_decoder.sv
// Quadrature paddle front end: synchroniser, per-channel stability filter, Gray decoder.
// Optional saturating illegal-transition counter enabled by QUAD_ERRCNT_EN.
module quad_paddle_decoder #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned POS_W    = 9,
    parameter int unsigned POS_MAX  = 511,
    parameter int unsigned POS_INIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             quadA,
    input  logic             quadB,
    output logic             quadA_clean,
    output logic             quadB_clean,
    output logic [POS_W-1:0] position,
    output logic             step_up,
    output logic             step_dn,
    output logic             illegal
`ifdef QUAD_ERRCNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_count
`endif
);

    localparam int unsigned CW = $clog2(FILT_LEN) + 1;
    localparam int unsigned PW = $clog2(FILT_LEN + 3);
    localparam logic [CW-1:0]    FiltTop  = CW'(FILT_LEN - 1);
    localparam logic [PW-1:0]    PrimeTop = PW'(FILT_LEN + 1);
    localparam logic [POS_W-1:0] PosMax   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] PosInit  = POS_W'(POS_INIT);

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Bit 1 carries channel A, bit 0 channel B.
    logic [1:0]       meta_q, sync_q;
    logic [1:0]       clean_q, clean_d;
    logic [1:0]       prev_q, prev_d;
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];
    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    prime_q, prime_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             up_q, up_d, dn_q, dn_d, ill_q, ill_d;
    logic [1:0]       changed;

    assign changed = prev_q ^ clean_q;

    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        clean_d = clean_q;
        prev_d  = clean_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        ill_d   = 1'b0;
        if (state_q == ST_PRIME) begin
            // Track the pins directly so release never decodes a phantom edge.
            clean_d = sync_q;
            prev_d  = sync_q;
            cnt_d   = '{default: '0};
            if (prime_q == PrimeTop) begin
                state_d = ST_RUN;
            end else begin
                prime_d = prime_q + PW'(1);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == FiltTop) begin
                    clean_d[i] = sync_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            if (changed == 2'b11) begin
                ill_d = 1'b1;
            end else if (changed != 2'b00) begin
                if (prev_q[1] ^ clean_q[0]) begin
                    up_d = 1'b1;
                    if (pos_q != PosMax) pos_d = pos_q + POS_W'(1);
                end else begin
                    dn_d = 1'b1;
                    if (pos_q != '0) pos_d = pos_q - POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            clean_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
            state_q <= ST_PRIME;
            prime_q <= '0;
            pos_q   <= PosInit;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            meta_q  <= {quadA, quadB};
            sync_q  <= meta_q;
            clean_q <= clean_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            prime_q <= prime_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            ill_q   <= ill_d;
        end
    end

`ifdef QUAD_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (ill_q && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`endif

    assign quadA_clean = clean_q[1];
    assign quadB_clean = clean_q[0];
    assign position    = pos_q;
    assign step_up     = up_q;
    assign step_dn     = dn_q;
    assign illegal     = ill_q;

endmodule
